// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_DM  = 1'b1;
    localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/unified_mem_arbiter_arb_pick.sv
// Combinational winner select between fetch and load/store requests.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise DM always wins over IF.
module arb_pick
    import unified_mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_win,
    output logic win
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        win = dm_req ? OWN_DM : OWN_IF;
        // On contention hand the slot to whoever did not win last time.
        if (if_req && dm_req) begin
            win = (last_win == OWN_IF) ? OWN_DM : OWN_IF;
        end
    end
`else
    logic unused_last_win;
    assign unused_last_win = last_win;
    assign win = dm_req ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Sequences one single-ported synchronous-read memory between fetch and load/store.
// Build option ARB_ROUND_ROBIN_EN selects round-robin instead of DM-first priority.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester raises req with stable addr/data and holds it until
    // it sees ack for one cycle; its inputs are captured on the grant edge only.

    state_t            state_q, state_d;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant;
    logic              gnt_own;
    logic              win;

    arb_pick u_pick (
        .if_req   (if_req),
        .dm_req   (dm_req),
        .last_win (owner_q),
        .win      (win)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        gnt_own = win;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                // The owner drops its request after this ack, so only the other side counts.
                if ((owner_q == OWN_IF) ? dm_req : if_req) begin
                    grant   = 1'b1;
                    gnt_own = ~owner_q;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= gnt_own;
                if (gnt_own == OWN_DM) begin
                    addr_q  <= dm_addr;
                    we_q    <= dm_we;
                    be_q    <= dm_be;
                    wdata_q <= dm_wdata;
                end else begin
                    addr_q  <= if_addr;
                    we_q    <= 1'b0;
                    be_q    <= BE_FULL;
                    wdata_q <= '0;
                end
            end
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_be    = mem_en ? be_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
    assign dm_ack    = (state_q == RESP) && (owner_q == OWN_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
